fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 31 +++
 rtl/fifo_wr_arbiter_if.sv | 29 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 93 +++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types, default parameters and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_BURST_MAX = 4;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int width;
    int rem;
    width = 0;
    rem   = value - 1;
    while (rem > 0) begin
      width++;
      rem = rem >> 1;
    end
    return width;
  endfunction

  // Index width that stays at least one bit for a single producer.
  function automatic int idx_width(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake and FIFO write-port signals shared by the producers and the arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_din;
  logic               fifo_full;

  // Producers plus the FIFO flag source.
  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_din
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            any_req
);

  logic [IW-1:0] idx;

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    winner = '0;
    idx    = '0;
    // Walk from the farthest candidate back to ptr so the nearest set request wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req[idx]) winner = idx;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-granting arbiter that lets NREQ producers share one synchronous FIFO write port.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ      = DEF_NREQ,
  parameter  int DW        = DEF_DW,
  parameter  int BURST_MAX = DEF_BURST_MAX,
  localparam int IW        = idx_width(NREQ),
  localparam int CW        = clog2(BURST_MAX + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  fifo_wr_arbiter_if.slave    bus,
  output logic [IW-1:0]       grant_id,
  output logic                busy
);

  state_t        state, state_nx;
  logic [IW-1:0] grant_nx;
  logic [IW-1:0] rr_ptr, rr_ptr_nx;
  logic [CW-1:0] beat_cnt, beat_cnt_nx;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [IW-1:0] ptr_after;
  logic          beat;
  logic [DW-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_split
    assign data_arr[i] = bus.req_data[i*DW +: DW];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .winner  (pick_idx),
    .any_req (pick_any)
  );

  assign ptr_after = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      grant_id <= grant_nx;
      rr_ptr   <= rr_ptr_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    grant_nx    = grant_id;
    rr_ptr_nx   = rr_ptr;
    beat_cnt_nx = beat_cnt;
    beat        = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nx = BURST;
          grant_nx = pick_idx;
        end
      end
      BURST: begin
        beat = bus.req_valid[grant_id] && !bus.fifo_full;
        // A full FIFO with valid still high simply holds the grant and the count.
        if (!bus.req_valid[grant_id] ||
            (beat && (bus.req_last[grant_id] || beat_cnt == CW'(BURST_MAX - 1)))) begin
          state_nx    = IDLE;
          rr_ptr_nx   = ptr_after;
          beat_cnt_nx = '0;
        end else if (beat) begin
          beat_cnt_nx = beat_cnt + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (beat) bus.req_ready[grant_id] = 1'b1;
  end

  assign bus.fifo_wr_en = beat;
  assign bus.fifo_din   = beat ? data_arr[grant_id] : '0;
  assign busy           = (state == BURST);

endmodule
